md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage, holding architectural HI/LO.
//  Accepts MIPS mult/multu/div/divu/mthi/mtlo and returns mfhi/mflo data.
//  Produces the busy/stall request that the hazard-detection logic consumes to freeze PC/IF-ID and clear ID-EX.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   issue strobe from EX, one cycle, qualified by md_op
//  md_op    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//  a        in   32  rs operand (dividend / mthi-mtlo source)
//  b        in   32  rt operand (divisor)
//  busy     out  1   operation in flight
//  md_stall out  1   busy | (start & md_op in 1..4); combinational, to stall unit
//  hi       out  32  HI register (mfhi source)
//  lo       out  32  LO register (mflo source)
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, counter=0, FSM=IDLE. Reset wins over every other input.
//  FSM states: IDLE, MUL, DIV.
//   IDLE + start + op 1/2 -> MUL, counter=MULT_CYCLES, operands latched at this edge.
//   IDLE + start + op 3/4 -> DIV, counter=DIV_CYCLES, operands latched.
//   IDLE + start + op 5 -> hi<=a next edge; op 6 -> lo<=a; no busy, stays IDLE.
//   op 0/7 with start: no effect.
//   MUL/DIV: counter decrements each cycle; at the edge where counter goes 1->0,
//    hi/lo are written and FSM returns to IDLE.
//  busy=1 exactly for MULT_CYCLES (or DIV_CYCLES) cycles, starting the cycle after start.
//  hi/lo hold their old values throughout; new values visible the cycle busy falls.
//  Back-to-back: start is accepted in the first cycle busy=0.
//  start while busy: ignored, hi/lo and counter unaffected (stall unit must prevent it;
//   the bench flags it as a protocol error).
//  Arithmetic:
//   mult: {hi,lo} = signed(a)*signed(b), 64-bit. multu: unsigned 64-bit product.
//   div: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//   divu: unsigned quotient/remainder.
//   Divide by zero (b==0): hi and lo unchanged, full DIV_CYCLES busy still spent.
//   div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Operands are latched at start; later changes on a/b do not affect the result.
//  Result computation is free to be combinational on latched operands; only the
//   timing of busy/hi/lo is contractual.
//  reset asserted mid-operation: operation aborted, hi=lo=0, busy=0 next cycle.
// TESTING
//  1 reset, start mult a=0xFFFFFFFF b=2 -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFE
//  2 multu a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles
//  3 div a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    divu a=7 b=0 with hi=lo=0x55 beforehand -> hi=lo=0x55 after 10 busy cycles
//  4 mthi a=0x1234 then mtlo a=0x5678 on next cycle -> hi=0x1234, lo=0x5678, busy never 1,
//    md_stall never 1
//  5 start mult; start divu a=9 b=4 while busy -> second start ignored;
//    start divu again first cycle busy=0 -> lo=2 hi=1
//  6 reset in 3rd cycle of div -> next cycle busy=0, hi=lo=0; md_stall=1 in cycle of any
//    mult/div start

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding architectural HI/LO
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             sign_q;

    logic             op_is_md;
    logic [63:0]      ext_a;
    logic [63:0]      ext_b;
    logic [63:0]      prod;
    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      divisor;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;

    // Stall request must be visible in the issue cycle itself, before busy rises
    always_comb begin
        op_is_md = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                   (md_op == OP_DIV)  || (md_op == OP_DIVU);
        busy     = (state != ST_IDLE);
        md_stall = busy || (start && op_is_md);
    end

    // Product on latched operands; sign- or zero-extending to 64 bits lets one
    // unsigned multiply serve both mult and multu
    always_comb begin
        ext_a = sign_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = sign_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;
    end

    // Quotient/remainder via magnitudes; quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        a_neg   = sign_q && a_q[31];
        b_neg   = sign_q && b_q[31];
        a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
        divisor = (b_q == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Control FSM, operand capture and HI/LO writeback; starts while busy are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                state  <= ST_MUL;
                                count  <= CNT_W'(MULT_CYCLES);
                                a_q    <= a;
                                b_q    <= b;
                                sign_q <= (md_op == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                state  <= ST_DIV;
                                count  <= CNT_W'(DIV_CYCLES);
                                a_q    <= a;
                                b_q    <= b;
                                sign_q <= (md_op == OP_DIV);
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                    end
                end
                ST_DIV: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        // Divide by zero leaves HI/LO untouched but still spends the full latency
                        if (b_q != 32'd0) begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
